z80_spi_mailbox: RTL and testbench



---
 rtl/z80_spi_mailbox.sv | 148 ++++++++++++++
 tb/tb_z80_spi_mailbox.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/z80_spi_mailbox.sv
// z80_spi_mailbox: Z80 I/O mailboxes bridged to the SB_SPI system bus as bus master
module z80_spi_mailbox #(
  parameter logic [15:0] IO_BASE = 16'd12345
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] z80_a,
  input  logic [7:0]  z80_d_in,
  output logic [7:0]  z80_d_out,
  output logic        z80_d_drive,
  output logic        z80_d_dir,
  output logic        z80_d_oe,
  input  logic        z80_rd,
  input  logic        z80_wr,
  input  logic        z80_m1,
  input  logic        z80_iorq,
  input  logic        z80_mreq,
  input  logic        spi_ss,
  output logic        sb_rw,
  output logic        sb_stb,
  output logic [7:0]  sb_adr,
  output logic [7:0]  sb_dati,
  input  logic [7:0]  sb_dato,
  input  logic        sb_ack,
  output logic        test_led
);
  localparam logic [2:0] CR0    = 3'd0;
  localparam logic [2:0] CR1    = 3'd1;
  localparam logic [2:0] CR2    = 3'd2;
  localparam logic [2:0] BR     = 3'd3;
  localparam logic [2:0] CSR    = 3'd4;
  localparam logic [2:0] RD_STS = 3'd5;
  localparam logic [2:0] TX     = 3'd6;
  localparam logic [2:0] RX     = 3'd7;
  logic [7:0] tx_mb [8];
  logic [7:0] rx_mb [8];
  logic [7:0] hit;
  logic [2:0] hit_k;
  logic       io_cyc;
  logic       rd_cyc;
  logic       ss_m;
  logic       ss_s;
  logic       old_ss;
  logic [2:0] state;
  logic [2:0] tx_idx;
  logic [2:0] rx_idx;
  logic [7:0] adr_c;
  logic [7:0] dati_c;
  logic       rw_c;
  assign io_cyc      = !z80_iorq && z80_mreq && z80_m1;
  assign rd_cyc      = !z80_rd && z80_wr && |hit;
  assign z80_d_drive = rd_cyc;
  assign z80_d_dir   = !rd_cyc;
  assign z80_d_out   = rd_cyc ? rx_mb[hit_k] : 8'hFF;
  assign z80_d_oe    = 1'b0;
  // decode which mailbox slot the current I/O cycle addresses
  always_comb begin
    hit   = '0;
    hit_k = '0;
    for (int i = 0; i < 8; i++)
      if (io_cyc && z80_a == IO_BASE + 16'(2 * i)) begin
        hit[i] = 1'b1;
        hit_k  = 3'(i);
      end
  end
  // Z80 OUT cycles fill the transmit mailbox; the last sample of the strobe wins
  always_ff @(posedge clk) begin
    if (!rst_n)
      tx_mb <= '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};
    else
      for (int i = 0; i < 8; i++)
        if (z80_rd && !z80_wr && hit[i]) tx_mb[i] <= z80_d_in;
  end
  // bring the asynchronous chip select into the clock domain, idle high
  always_ff @(posedge clk) begin
    if (!rst_n) {ss_s, ss_m} <= 2'b11;
    else {ss_s, ss_m} <= {ss_m, spi_ss};
  end
  // bus address, direction and write data for the transaction of the current state
  always_comb begin
    adr_c  = 8'h0C;
    rw_c   = 1'b1;
    dati_c = 8'h00;
    case (state)
      CR0:     adr_c = 8'h08;
      CR1:     begin adr_c = 8'h09; dati_c = 8'h80; end
      CR2:     begin adr_c = 8'h0A; dati_c = 8'h01; end
      BR:      adr_c = 8'h0B;
      CSR:     adr_c = 8'h0F;
      RD_STS:  rw_c = 1'b0;
      TX:      begin adr_c = 8'h0D; dati_c = tx_mb[tx_idx]; end
      default: begin adr_c = 8'h0E; rw_c = 1'b0; end
    endcase
  end
  // bus master: issue a strobe, wait for ack, then step the sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CR0;
      sb_stb   <= 1'b0;
      sb_rw    <= 1'b0;
      sb_adr   <= 8'h00;
      sb_dati  <= 8'h00;
      old_ss   <= 1'b0;
      tx_idx   <= 3'd0;
      rx_idx   <= 3'd0;
      test_led <= 1'b1;
      rx_mb    <= '{8'd111, 8'd122, 8'd133, 8'd144, 8'd155, 8'd166, 8'd177, 8'd188};
    end else if (!sb_stb) begin
      sb_stb  <= 1'b1;
      sb_adr  <= adr_c;
      sb_rw   <= rw_c;
      sb_dati <= dati_c;
      if (state == TX) tx_idx <= tx_idx + 3'd1;
    end else if (sb_ack) begin
      sb_stb <= 1'b0;
      case (state)
        RD_STS: begin
          if (!ss_s && old_ss) begin
            old_ss <= 1'b0;
            rx_idx <= 3'd0;
            tx_idx <= 3'd0;
            state  <= TX;
          end
          if (!ss_s && sb_dato[4]) begin
            test_led <= 1'b0;
            state    <= TX;
          end else if (!ss_s && sb_dato[3]) begin
            test_led <= 1'b0;
            state    <= RX;
          end
          if (ss_s && !old_ss) begin
            old_ss   <= 1'b1;
            test_led <= 1'b1;
            tx_idx   <= 3'd0;
            state    <= TX;
          end
        end
        TX: state <= RD_STS;
        RX: begin
          rx_mb[rx_idx] <= sb_dato;
          rx_idx        <= rx_idx + 3'd1;
          state         <= RD_STS;
        end
        default: state <= state + 3'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_z80_spi_mailbox.sv
// tb_z80_spi_mailbox: randomized bus/Z80 stimulus against a transaction-level mailbox model
module tb_z80_spi_mailbox;
  localparam logic [15:0] BASE = 16'd12345;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] z80_a = 16'h0000;
  logic [7:0]  z80_d_in = 8'h00;
  logic [7:0]  z80_d_out;
  logic        z80_d_drive, z80_d_dir, z80_d_oe;
  logic        z80_rd = 1'b1, z80_wr = 1'b1, z80_m1 = 1'b1, z80_iorq = 1'b1, z80_mreq = 1'b1;
  logic        spi_ss = 1'b1;
  logic        sb_rw, sb_stb;
  logic [7:0]  sb_adr, sb_dati;
  logic [7:0]  sb_dato = 8'h00;
  logic        sb_ack = 1'b0;
  logic        test_led;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  cfg_a [5] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0F};
  logic [7:0]  cfg_d [5] = '{8'h00, 8'h80, 8'h01, 8'h00, 8'h00};
  logic [7:0]  m_tx [8];
  logic [7:0]  m_rx [8];
  logic [2:0]  m_ti, m_ri;
  logic        m_old, m_led;
  int          m_cfg;
  int          m_next;
  int          m_last;

  z80_spi_mailbox #(.IO_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .z80_a(z80_a), .z80_d_in(z80_d_in),
    .z80_d_out(z80_d_out), .z80_d_drive(z80_d_drive), .z80_d_dir(z80_d_dir),
    .z80_d_oe(z80_d_oe), .z80_rd(z80_rd), .z80_wr(z80_wr), .z80_m1(z80_m1),
    .z80_iorq(z80_iorq), .z80_mreq(z80_mreq), .spi_ss(spi_ss), .sb_rw(sb_rw),
    .sb_stb(sb_stb), .sb_adr(sb_adr), .sb_dati(sb_dati), .sb_dato(sb_dato),
    .sb_ack(sb_ack), .test_led(test_led)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tx   = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};
    m_rx   = '{8'd111, 8'd122, 8'd133, 8'd144, 8'd155, 8'd166, 8'd177, 8'd188};
    m_ti   = 3'd0;
    m_ri   = 3'd0;
    m_old  = 1'b0;
    m_led  = 1'b1;
    m_cfg  = 0;
    m_next = 0;
  endtask

  function automatic int slot_of(input logic [15:0] a, input logic m1);
    logic [15:0] d;
    d = a - BASE;
    return (m1 && !d[0] && d < 16'd16) ? int'(d[3:1]) : -1;
  endfunction

  task automatic z80_out(input logic [15:0] a, input logic m1, input logic [7:0] d);
    int s;
    s = slot_of(a, m1);
    z80_a = a; z80_m1 = m1; z80_d_in = d; z80_iorq = 1'b0; z80_wr = 1'b0;
    @(negedge clk);
    z80_iorq = 1'b1; z80_wr = 1'b1; z80_m1 = 1'b1;
    if (s >= 0) m_tx[s] = d;
  endtask

  task automatic z80_in(input logic [15:0] a, input logic m1);
    int s;
    s = slot_of(a, m1);
    z80_a = a; z80_m1 = m1; z80_iorq = 1'b0; z80_rd = 1'b0;
    #1;
    chk("z80_drive", z80_d_drive, s >= 0);
    chk("z80_dir", z80_d_dir, s < 0);
    chk("z80_data", z80_d_out, s >= 0 ? m_rx[s] : 8'hFF);
    chk("z80_oe", z80_d_oe, 0);
    #1;
    z80_iorq = 1'b1; z80_rd = 1'b1; z80_m1 = 1'b1;
  endtask

  task automatic rand_op();
    logic [15:0] a, na;
    logic        nm1;
    logic [7:0]  d;
    a = BASE + 16'(2 * $urandom_range(0, 7));
    d = 8'($urandom);
    nm1 = 1'($urandom_range(0, 1));
    na = nm1 ? a + 16'd1 : a;
    case ($urandom_range(0, 3))
      0: z80_out(a, 1'b1, d);
      1: z80_in(a, 1'b1);
      2: z80_in(na, nm1);
      default: z80_out(na, nm1, d);
    endcase
  endtask

  task automatic model_ack(input logic [7:0] d);
    int n;
    m_last = -1;
    if (m_cfg < 5) m_cfg++;
    else if (m_next == 1) m_next = 0;
    else if (m_next == 2) begin
      m_rx[m_ri] = d;
      m_last = int'(m_ri);
      m_ri++;
      m_next = 0;
    end else begin
      n = 0;
      if (!spi_ss && m_old) begin m_old = 1'b0; m_ri = 3'd0; m_ti = 3'd0; n = 1; end
      if (!spi_ss && d[4]) begin m_led = 1'b0; n = 1; end
      else if (!spi_ss && d[3]) begin m_led = 1'b0; n = 2; end
      if (spi_ss && !m_old) begin m_old = 1'b1; m_led = 1'b1; m_ti = 3'd0; n = 1; end
      m_next = n;
    end
  endtask

  task automatic wait_stb();
    int t = 0;
    while (!sb_stb && t < 20) begin @(negedge clk); t++; end
    if (!sb_stb) begin
      chk("stb_timeout", sb_stb, 1);
      $fatal(1, "strobe never issued");
    end
  endtask

  task automatic do_txn(input int st, input int ops, input int ss_set);
    logic [7:0] ea, ed, dato;
    logic       er;
    wait_stb();
    if (m_cfg < 5) begin ea = cfg_a[m_cfg]; er = 1'b1; ed = cfg_d[m_cfg]; end
    else if (m_next == 1) begin ea = 8'h0D; er = 1'b1; ed = m_tx[m_ti]; end
    else if (m_next == 2) begin ea = 8'h0E; er = 1'b0; ed = 8'h00; end
    else begin ea = 8'h0C; er = 1'b0; ed = 8'h00; end
    chk("sb_adr", sb_adr, ea);
    chk("sb_rw", sb_rw, er);
    if (er) chk("sb_dati", sb_dati, ed);
    if (m_cfg >= 5 && m_next == 1) m_ti++;
    if (ss_set >= 0) begin
      spi_ss = ss_set[0];
      repeat (4) @(negedge clk);
    end
    repeat (ops) rand_op();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (st >= 0) dato = 8'(st);
    else if (m_cfg >= 5 && m_next == 0) dato = (8'($urandom) & 8'hE7) | 8'($urandom_range(0, 3) << 3);
    else dato = 8'($urandom);
    sb_dato = dato;
    sb_ack = 1'b1;
    @(negedge clk);
    sb_ack = 1'b0;
    chk("stb_drop", sb_stb, 0);
    model_ack(dato);
    chk("test_led", test_led, m_led);
    if (m_last >= 0) z80_in(BASE + 16'(2 * m_last), 1'b1);
  endtask

  task automatic to_poll();
    for (int i = 0; i < 4 && (m_cfg < 5 || m_next != 0); i++) do_txn(-1, 0, -1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_stb", sb_stb, 0);
    chk("rst_rw", sb_rw, 0);
    chk("rst_adr", sb_adr, 0);
    chk("rst_dati", sb_dati, 0);
    chk("rst_led", test_led, 1);
    chk("rst_oe", z80_d_oe, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_stb", sb_stb, 1);
    repeat (5) do_txn(-1, 0, -1);
    do_txn(-1, 0, -1);
    do_txn(-1, 0, -1);
    z80_out(BASE + 16'd4, 1'b1, 8'hA5);
    z80_in(BASE + 16'd14, 1'b1);
    z80_in(BASE + 16'd1, 1'b1);
    z80_in(BASE, 1'b0);
    z80_out(BASE + 16'd1, 1'b1, 8'h5A);
    z80_out(BASE + 16'd6, 1'b0, 8'h5A);
    repeat (10) do_txn(-1, 2, -1);
    to_poll();
    do_txn(8'h08, 0, 0);
    do_txn(8'h3C, 0, -1);
    do_txn(8'h10, 0, -1);
    do_txn(-1, 0, -1);
    do_txn(8'h10, 0, -1);
    do_txn(-1, 0, -1);
    repeat (60) do_txn(-1, $urandom_range(0, 2), -1);
    to_poll();
    do_txn(-1, 0, 1);
    do_txn(-1, 0, -1);
    to_poll();
    do_txn(8'h08, 0, 0);
    do_txn(-1, 0, -1);
    repeat (8) begin
      do_txn(8'h08, 0, -1);
      do_txn(-1, 0, -1);
    end
    spi_ss = 1'b1;
    wait_stb();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_stb", sb_stb, 0);
    chk("midrst_led", test_led, 1);
    rst_n = 1'b1;
    model_reset();
    repeat (5) do_txn(-1, 1, -1);
    repeat (6) do_txn(-1, 1, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
